// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
// The optional SEQ_DIVIDER_ROUND_EN build rounds the quotient half away from zero.
package seq_divider_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    // Edges from the accept edge to the edge that raises dout_valid.
    function automatic int latency(input int n);
        return n + 1;
    endfunction

    function automatic logic [63:0] max_pos(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] min_neg(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider; master drives operands, slave returns results.
interface seq_divider_if #(
    parameter int DIN1_WIDTH = 32,
    parameter int DIN2_WIDTH = 16
);
    logic signed [DIN1_WIDTH-1:0] din1;
    logic signed [DIN2_WIDTH-1:0] din2;
    logic                         din_valid;
    logic                         din_ready;
    logic signed [DIN1_WIDTH-1:0] dout_quot;
    logic signed [DIN2_WIDTH-1:0] dout_rem;
    logic                         dout_valid;
    logic                         div_by_zero;
    logic                         dout_sat;

    modport master (
        output din1, din2, din_valid,
        input  din_ready, dout_quot, dout_rem, dout_valid, div_by_zero, dout_sat
    );

    modport slave (
        input  din1, din2, din_valid,
        output din_ready, dout_quot, dout_rem, dout_valid, div_by_zero, dout_sat
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor magnitude.
module div_step #(
    parameter int M = 16
) (
    input  logic [M:0]   rem_i,
    input  logic [M-1:0] div_i,
    input  logic         bit_i,
    output logic [M:0]   rem_o,
    output logic         q_o
);
    logic [M+1:0] sh;

    assign sh    = {rem_i, bit_i};
    assign q_o   = (sh >= {2'b00, div_i});
    // On success the difference is below the divisor, so M+1 bits hold it.
    assign rem_o = q_o ? (sh[M:0] - {1'b0, div_i}) : sh[M:0];
endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider retiring one quotient bit per clock (IDLE -> CALC -> FIX).
// Define SEQ_DIVIDER_ROUND_EN to round the quotient half away from zero in FIX.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DIN1_WIDTH = 32,
    parameter int DIN2_WIDTH = 16
) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);
    localparam int N  = DIN1_WIDTH;
    localparam int M  = DIN2_WIDTH;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [63:0]   MAXP64   = max_pos(N);
    localparam logic [63:0]   MINN64   = min_neg(N);
    localparam logic [N-1:0]  MAX_POS  = MAXP64[N-1:0];
    localparam logic [N-1:0]  MIN_NEG  = MINN64[N-1:0];

    state_e        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [M-1:0]  b_q, b_d;
    logic [M:0]    r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sq_q, sq_d, sr_q, sr_d, zero_q, zero_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [M-1:0]  rem_q, rem_d;
    logic          vld_q, vld_d, dbz_q, dbz_d, sat_q, sat_d;

    logic [M:0]    r_next;
    logic          q_bit;
    logic [N-1:0]  din1_mag;
    logic [M-1:0]  din2_mag;
    logic [N:0]    qmag;
    logic          pos_ovf, neg_ovf;
    logic [N-1:0]  fix_quot;
    logic [M-1:0]  fix_rem;

    div_step #(.M(M)) u_step (
        .rem_i (r_q),
        .div_i (b_q),
        .bit_i (a_q[N-1]),
        .rem_o (r_next),
        .q_o   (q_bit)
    );

    assign din1_mag = bus.din1[N-1] ? -bus.din1 : bus.din1;
    assign din2_mag = bus.din2[M-1] ? -bus.din2 : bus.din2;

`ifdef SEQ_DIVIDER_ROUND_EN
    logic round_up;
    assign round_up = ({r_q[M-1:0], 1'b0} >= {1'b0, b_q});
    assign qmag     = {1'b0, a_q} + {{N{1'b0}}, round_up};
`else
    assign qmag     = {1'b0, a_q};
`endif

    // A positive result cannot reach 2^(N-1); a negative one may equal it exactly.
    assign pos_ovf = !sq_q && (qmag >= {1'b0, MIN_NEG});
    assign neg_ovf =  sq_q && (qmag >  {1'b0, MIN_NEG});

    always_comb begin
        fix_quot = sq_q ? -qmag[N-1:0] : qmag[N-1:0];
        if (zero_q)       fix_quot = sr_q ? MIN_NEG : MAX_POS;
        else if (pos_ovf) fix_quot = MAX_POS;
        else if (neg_ovf) fix_quot = MIN_NEG;
        fix_rem = zero_q ? '0 : (sr_q ? -r_q[M-1:0] : r_q[M-1:0]);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        vld_d   = 1'b0;
        dbz_d   = dbz_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: if (bus.din_valid) begin
                a_d     = din1_mag;
                b_d     = din2_mag;
                sq_d    = bus.din1[N-1] ^ bus.din2[M-1];
                sr_d    = bus.din1[N-1];
                zero_d  = (bus.din2 == '0);
                r_d     = '0;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                // Quotient bits fill a_q from the bottom as dividend bits leave the top.
                a_d   = {a_q[N-2:0], q_bit};
                r_d   = r_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = FIX;
            end
            FIX: begin
                quot_d  = fix_quot;
                rem_d   = fix_rem;
                dbz_d   = zero_q;
                sat_d   = zero_q | pos_ovf | neg_ovf;
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            vld_q   <= 1'b0;
            dbz_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            vld_q   <= vld_d;
            dbz_q   <= dbz_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.din_ready   = (state_q == IDLE);
    assign bus.dout_quot   = quot_q;
    assign bus.dout_rem    = rem_q;
    assign bus.dout_valid  = vld_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.dout_sat    = sat_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corners, random ops vs. an arithmetic model,
// back-to-back strobing and mid-operation reset.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int N   = 32;
    localparam int M   = 16;
    localparam int LAT = latency(N);

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    seq_divider_if #(.DIN1_WIDTH(N), .DIN2_WIDTH(M)) bus ();

    seq_divider #(.DIN1_WIDTH(N), .DIN2_WIDTH(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic void ref_div(input logic signed [31:0] a, input logic signed [15:0] b,
                                    output logic signed [31:0] q, output logic signed [15:0] r,
                                    output logic dbz, output logic sat);
        longint la, lb, am, bm, qm, rm, lq, lr;
        la = a;
        lb = b;
        if (lb == 0) begin
            q   = (la >= 0) ? 32'sh7FFF_FFFF : 32'sh8000_0000;
            r   = '0;
            dbz = 1'b1;
            sat = 1'b1;
            return;
        end
        am = (la < 0) ? -la : la;
        bm = (lb < 0) ? -lb : lb;
        qm = am / bm;
        rm = am % bm;
`ifdef SEQ_DIVIDER_ROUND_EN
        if (2 * rm >= bm) qm = qm + 1;
`endif
        lq  = ((la < 0) != (lb < 0)) ? -qm : qm;
        lr  = (la < 0) ? -rm : rm;
        dbz = 1'b0;
        sat = 1'b0;
        if (lq > 64'sd2147483647)  begin lq = 64'sd2147483647;  sat = 1'b1; end
        if (lq < -64'sd2147483648) begin lq = -64'sd2147483648; sat = 1'b1; end
        q = lq[31:0];
        r = lr[15:0];
    endfunction

    function automatic logic signed [31:0] rnd_a();
        case ($urandom_range(0, 4))
            0:       return 32'sh8000_0000;
            1:       return 32'($urandom_range(0, 2000)) - 32'sd1000;
            2:       return 32'sh7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic signed [15:0] rnd_b();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0:       return 16'sd0;
            1:       return v[0] ? 16'sd1 : -16'sd1;
            2:       return 16'sh8000;
            3:       return 16'(v[4:0]) - 16'sd16;
            default: return v[15:0];
        endcase
    endfunction

    // Runs one operation; lat = edges from accept to dout_valid (-1 on timeout).
    task automatic do_op(input logic signed [31:0] a, input logic signed [15:0] b,
                         output logic signed [31:0] q, output logic signed [15:0] r,
                         output logic dbz, output logic sat, output int lat, output logic one_wide);
        int w;
        lat = -1; q = '0; r = '0; dbz = 1'b0; sat = 1'b0; one_wide = 1'b0;
        w = 0;
        @(negedge clk);
        while (!bus.din_ready && w < 100) begin @(negedge clk); w++; end
        if (!bus.din_ready) return;
        bus.din1 = a;
        bus.din2 = b;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1 bus.din_valid = 1'b0;
        bus.din1 = $urandom;
        bus.din2 = $urandom;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.dout_valid) begin
                lat = k;
                q = bus.dout_quot; r = bus.dout_rem;
                dbz = bus.div_by_zero; sat = bus.dout_sat;
                break;
            end
        end
        if (lat < 0) return;
        @(posedge clk);
        #1 one_wide = !bus.dout_valid && (bus.dout_quot === q) && (bus.dout_rem === r);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.din_valid = 1'b0;
        bus.din1 = '0;
        bus.din2 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.dout_quot, bus.dout_rem, bus.dout_valid, bus.div_by_zero, bus.dout_sat} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got q=%h r=%h v=%b z=%b s=%b, want all 0",
                     bus.dout_quot, bus.dout_rem, bus.dout_valid, bus.div_by_zero, bus.dout_sat);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.din_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", bus.din_ready);
        end
    endtask

    task automatic test_latency();
        logic signed [31:0] q; logic signed [15:0] r; logic z, s, w; int lat;
        do_op(32'sd1000, 16'sd7, q, r, z, s, lat, w);
        n_cmp++;
        if (lat !== LAT) begin n_err++; $display("FAIL latency: got %0d want %0d", lat, LAT); end
        n_cmp++;
        if (w !== 1'b1) begin n_err++; $display("FAIL pulse_width_hold: got %b want 1", w); end
    endtask

    task automatic test_directed();
`ifdef SEQ_DIVIDER_ROUND_EN
        logic signed [31:0] ta[5] = '{32'sd1000, 32'sd20, -32'sd20, 32'sh7FFF_FFFF, 32'sd5};
        logic signed [15:0] tb[5] = '{16'sd7, 16'sd8, 16'sd8, 16'sd1, 16'sd0};
        logic signed [31:0] eq[5] = '{32'sd143, 32'sd3, -32'sd3, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF};
        logic signed [15:0] er[5] = '{16'sd6, 16'sd4, -16'sd4, 16'sd0, 16'sd0};
        logic               ez[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic               es[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        logic signed [31:0] ta[7] = '{32'sd1000, -32'sd1000, 32'sd1000, 32'sd5, -32'sd5,
                                      32'sh8000_0000, 32'sh8000_0000};
        logic signed [15:0] tb[7] = '{16'sd7, 16'sd7, -16'sd7, 16'sd0, 16'sd0, -16'sd1, 16'sd1};
        logic signed [31:0] eq[7] = '{32'sd142, -32'sd142, -32'sd142, 32'sh7FFF_FFFF,
                                      32'sh8000_0000, 32'sh7FFF_FFFF, 32'sh8000_0000};
        logic signed [15:0] er[7] = '{16'sd6, -16'sd6, 16'sd6, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        logic               ez[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic               es[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        logic signed [31:0] q; logic signed [15:0] r; logic z, s, w; int lat;
        for (int i = 0; i < $size(ta); i++) begin
            do_op(ta[i], tb[i], q, r, z, s, lat, w);
            n_cmp++;
            if ({q, r, z, s} !== {eq[i], er[i], ez[i], es[i]} || lat !== LAT) begin
                n_err++;
                $display("FAIL directed_%0d %0d/%0d: got q=%h r=%h z=%b s=%b lat=%0d want q=%h r=%h z=%b s=%b lat=%0d",
                         i, ta[i], tb[i], q, r, z, s, lat, eq[i], er[i], ez[i], es[i], LAT);
            end
        end
    endtask

    task automatic test_random(input int n_ops);
        logic signed [31:0] a, q, eq; logic signed [15:0] b, r, er;
        logic z, s, ez, es, w; int lat;
        for (int i = 0; i < n_ops; i++) begin
            a = rnd_a();
            b = rnd_b();
            ref_div(a, b, eq, er, ez, es);
            do_op(a, b, q, r, z, s, lat, w);
            n_cmp++;
            if ({q, r, z, s} !== {eq, er, ez, es} || lat !== LAT || w !== 1'b1) begin
                n_err++;
                $display("FAIL random %0d/%0d: got q=%h r=%h z=%b s=%b lat=%0d w=%b want q=%h r=%h z=%b s=%b lat=%0d w=1",
                         a, b, q, r, z, s, lat, w, eq, er, ez, es, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] qa[$]; logic signed [15:0] qb[$]; int acc[$];
        logic signed [31:0] a, eq; logic signed [15:0] b, er; logic ez, es;
        int n_out;
        n_out = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            bus.din_valid = (c < 100);
            bus.din1 = rnd_a();
            bus.din2 = rnd_b();
            if (bus.din_valid && bus.din_ready) begin
                qa.push_back(bus.din1); qb.push_back(bus.din2); acc.push_back(c);
            end
            @(posedge clk);
            #1;
            if (bus.dout_valid) begin
                n_out++;
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_spurious: dout_valid at cycle %0d with nothing pending", c);
                end else begin
                    a = qa.pop_front(); b = qb.pop_front();
                    ref_div(a, b, eq, er, ez, es);
                    if ({bus.dout_quot, bus.dout_rem, bus.div_by_zero, bus.dout_sat} !== {eq, er, ez, es}) begin
                        n_err++;
                        $display("FAIL b2b_result %0d/%0d: got q=%h r=%h z=%b s=%b want q=%h r=%h z=%b s=%b",
                                 a, b, bus.dout_quot, bus.dout_rem, bus.div_by_zero, bus.dout_sat, eq, er, ez, es);
                    end
                end
            end
        end
        bus.din_valid = 1'b0;
        n_cmp++;
        if (acc.size() !== 3 || n_out !== 3) begin
            n_err++;
            $display("FAIL b2b_count: got accepts=%0d results=%0d want 3 and 3", acc.size(), n_out);
        end
        for (int i = 1; i < acc.size(); i++) begin
            n_cmp++;
            if (acc[i] - acc[i-1] !== LAT + 1) begin
                n_err++;
                $display("FAIL b2b_spacing: got %0d want %0d", acc[i] - acc[i-1], LAT + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [31:0] q, eq; logic signed [15:0] r, er; logic z, s, ez, es, w; int lat;
        logic seen;
        do_op(32'sd1000, 16'sd7, q, r, z, s, lat, w);
        @(negedge clk);
        bus.din1 = -32'sd123456; bus.din2 = 16'sd77; bus.din_valid = 1'b1;
        @(posedge clk);
        #1 bus.din_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.dout_quot, bus.dout_rem, bus.dout_valid, bus.div_by_zero, bus.dout_sat} !== '0
            || bus.din_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_clear: got q=%h r=%h v=%b z=%b s=%b rdy=%b want zeros, rdy=1",
                     bus.dout_quot, bus.dout_rem, bus.dout_valid, bus.div_by_zero, bus.dout_sat, bus.din_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1 if (bus.dout_valid) seen = 1'b1; end
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_novalid: got dout_valid=1 want none"); end
        ref_div(-32'sd98765, -16'sd321, eq, er, ez, es);
        do_op(-32'sd98765, -16'sd321, q, r, z, s, lat, w);
        n_cmp++;
        if ({q, r, z, s} !== {eq, er, ez, es} || lat !== LAT) begin
            n_err++;
            $display("FAIL midreset_next: got q=%h r=%h z=%b s=%b lat=%0d want q=%h r=%h z=%b s=%b lat=%0d",
                     q, r, z, s, lat, eq, er, ez, es, LAT);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_latency();
        test_directed();
        test_random(600);
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
